// File: rtl/uart_input_scheduler.sv
// uart_input_scheduler
// Packs received UART bytes into words, queues them in a small FIFO and
// serves UARTtoReg read requests from writeback, stalling the pipeline
// while a request waits for data.
// Optional build macro: UART_INPUT_LITTLE_ENDIAN_EN (first byte lands in
// bits [7:0]); when undefined the first byte is the most significant.
module uart_input_scheduler #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int BYTES_PER_WORD  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_byte,
    input  logic                       req,
    output logic                       input_ready,
    output logic [31:0]                input_data,
    output logic                       stall,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       overrun
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [31:0] WORD_MASK = (BYTES_PER_WORD == 4) ? 32'hFFFF_FFFF
                                      : ((32'h1 << (8 * BYTES_PER_WORD)) - 32'h1);

    typedef enum logic [1:0] {IDLE, WAIT, DELIVER} state_t;

    state_t                       state_reg, state_next;
    logic [31:0]                  asm_reg;
    logic [1:0]                   byte_cnt_reg;
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_DEPTH_LOG2:0]     count_reg;
    logic [31:0]                  input_data_reg;
    logic                         overrun_reg;
    logic [31:0]                  mem [DEPTH];

    logic [31:0] asm_shift;
    logic [31:0] word_in;
    logic        word_done;
    logic        have_word;
    logic        full;
    logic        take;      // pop the FIFO head into input_data
    logic        bypass;    // hand the word being completed straight to a waiting request
    logic        push;
    logic        accept;
    logic        drop;

`ifdef UART_INPUT_LITTLE_ENDIAN_EN
    // New bytes enter at the top; after a full word the bytes sit in the
    // upper lanes, oldest lowest, so shift them down into place.
    assign asm_shift = {rx_byte, asm_reg[31:8]};
    assign word_in   = asm_shift >> (32 - 8 * BYTES_PER_WORD);
`else
    // New bytes enter at the bottom; the oldest byte ends up most significant.
    assign asm_shift = {asm_reg[23:0], rx_byte};
    assign word_in   = asm_shift & WORD_MASK;
`endif

    assign word_done = rx_valid && (byte_cnt_reg == LAST_BYTE);
    assign have_word = (count_reg != '0);
    assign full      = (count_reg == FULL_COUNT);
    assign push      = word_done && !bypass;
    // A pop in the same edge frees a slot, so a full FIFO still accepts.
    assign accept    = push && (!full || take);
    assign drop      = push && full && !take;

    assign input_ready = (state_reg == DELIVER);
    assign input_data  = input_data_reg;
    assign fifo_count  = count_reg;
    assign overrun     = overrun_reg;
    assign stall       = req && !input_ready;

    // Request-service next-state logic: decides when to pop or bypass.
    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        bypass     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (have_word) begin
                        take       = 1'b1;
                        state_next = DELIVER;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (have_word) begin
                    take       = 1'b1;
                    state_next = DELIVER;
                end else if (word_done) begin
                    bypass     = 1'b1;
                    state_next = DELIVER;
                end
            end
            DELIVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset cancels a delivery pulse immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Byte assembly: shift register plus position-in-word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_reg      <= '0;
            byte_cnt_reg <= '0;
        end else if (rx_valid) begin
            asm_reg      <= asm_shift;
            byte_cnt_reg <= word_done ? 2'd0 : byte_cnt_reg + 2'd1;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= word_in;
        end
    end

    // FIFO pointers, occupancy and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (take) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({accept, take})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Delivered word register; holds its value between deliveries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            input_data_reg <= '0;
        end else if (take) begin
            input_data_reg <= mem[rd_ptr_reg];
        end else if (bypass) begin
            input_data_reg <= word_in;
        end
    end

endmodule

// File: tb/tb_uart_input_scheduler.sv
// tb_uart_input_scheduler
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based model of the scheduler. Honours UART_INPUT_LITTLE_ENDIAN_EN.
module tb_uart_input_scheduler;

    localparam int LOG2  = 2;
    localparam int DEPTH = 4;
    localparam int BPW   = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_byte = 8'h00;
    logic            req = 1'b0;
    logic            input_ready;
    logic [31:0]     input_data;
    logic            stall;
    logic [LOG2:0]   fifo_count;
    logic            overrun;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    uart_input_scheduler #(
        .FIFO_DEPTH_LOG2 (LOG2),
        .BYTES_PER_WORD  (BPW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .req         (req),
        .input_ready (input_ready),
        .input_data  (input_data),
        .stall       (stall),
        .fifo_count  (fifo_count),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte order of a word as a plain function of the byte list.
    function automatic logic [31:0] pack(input logic [7:0] b[$]);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < b.size(); i++) begin
`ifdef UART_INPUT_LITTLE_ENDIAN_EN
            w = w | (32'(b[i]) << (8 * i));
`else
            w = (w << 8) | 32'(b[i]);
`endif
        end
        return w;
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        logic [7:0] t[$];
        t = {a, b, c, d};
        return pack(t);
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  parts[$];
    logic [31:0] q[$];
    bit          m_ready = 1'b0;
    bit          m_wait  = 1'b0;
    bit          m_ovr   = 1'b0;
    logic [31:0] m_data  = 32'h0;

    // Model: a request is served from the queue head, or directly by a word
    // completing while the request was already waiting; a delivery cycle
    // ignores req; a completed word not handed over joins the queue if room.
    always @(posedge clk or negedge reset_n) begin
        logic [7:0]  t[$];
        logic [31:0] w;
        bit          comp;
        bit          byp;
        bit          nr;
        if (!reset_n) begin
            parts.delete();
            q.delete();
            m_ready = 1'b0;
            m_wait  = 1'b0;
            m_ovr   = 1'b0;
            m_data  = 32'h0;
        end else begin
            comp = rx_valid && (parts.size() == BPW - 1);
            t = parts;
            t.push_back(rx_byte);
            w = pack(t);
            nr  = 1'b0;
            byp = 1'b0;
            if (!m_ready && req) begin
                if (q.size() > 0) begin
                    m_data = q.pop_front();
                    nr = 1'b1;
                end else if (m_wait && comp) begin
                    m_data = w;
                    byp = 1'b1;
                    nr = 1'b1;
                end
            end
            m_wait = req && !m_ready && !nr;
            if (comp && !byp) begin
                if (q.size() < DEPTH) q.push_back(w);
                else m_ovr = 1'b1;
            end
            if (rx_valid) begin
                if (comp) parts.delete();
                else parts.push_back(rx_byte);
            end
            m_ready = nr;
        end
    end

    // Compare DUT against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("input_ready", 32'(input_ready), 32'(m_ready));
            chk("input_data",  input_data, m_data);
            chk("fifo_count",  32'(fifo_count), 32'(q.size()));
            chk("overrun",     32'(overrun), 32'(m_ovr));
            chk("stall",       32'(stall), 32'(req && !m_ready));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!input_ready && n < 200);
        if (!input_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: input_ready still 0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic do_req(output logic [31:0] d);
        int n;
        req = 1'b1;
        wait_ready(n);
        d = input_data;
        $display("deliver word %08h after %0d cycles", d, n);
        tick();
        req = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] d;

        // Scenario 1: reset, one word, one request
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        chk_on = 1'b1;
        tick();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        @(negedge clk);
        chk("s1_count", 32'(fifo_count), 32'd1);
        chk("s1_no_ready", 32'(input_ready), 32'd0);
        tick();
        req = 1'b1;
        @(negedge clk);
        chk("s1_stall_req_cycle", 32'(stall), 32'd1);
        wait_ready(n);
        chk("s1_latency", 32'(n), 32'd1);
`ifdef UART_INPUT_LITTLE_ENDIAN_EN
        chk("s1_data", input_data, 32'h78563412);
`else
        chk("s1_data", input_data, 32'h12345678);
`endif
        chk("s1_stall_ready_cycle", 32'(stall), 32'd0);
        chk("s1_count_after", 32'(fifo_count), 32'd0);
        $display("deliver word %08h after %0d cycles", input_data, n + 1);
        tick();
        req = 1'b0;
        tick();

        // Scenario 2: request on empty FIFO, word arrives while waiting
        req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("s2_stall_wait", 32'(stall), 32'd1);
        end
        tick();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        @(negedge clk);
        chk("s2_ready_after_push", 32'(input_ready), 32'd1);
        chk("s2_data", input_data, pack4(8'hAA, 8'hBB, 8'hCC, 8'hDD));
        chk("s2_stall_drop", 32'(stall), 32'd0);
        $display("deliver word %08h after wait", input_data);
        tick();
        req = 1'b0;
        tick();

        // Scenario 3: overrun with five words into a four-deep FIFO
        reset_pulse();
        for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
        @(negedge clk);
        chk("s3_count_full", 32'(fifo_count), 32'd4);
        chk("s3_overrun", 32'(overrun), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            do_req(d);
            chk("s3_drain", d, pack4(8'(16 + 4 * k), 8'(17 + 4 * k), 8'(18 + 4 * k), 8'(19 + 4 * k)));
        end
        @(negedge clk);
        chk("s3_empty", 32'(fifo_count), 32'd0);
        tick();

        // Scenario 4: push and pop in the same edge while full
        reset_pulse();
        for (int i = 0; i < 19; i++) send_byte(8'(8'h40 + i));
        req = 1'b1;
        rx_valid = 1'b1;
        rx_byte = 8'h53;
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        chk("s4_ready", 32'(input_ready), 32'd1);
        chk("s4_first", input_data, pack4(8'h40, 8'h41, 8'h42, 8'h43));
        chk("s4_count_kept", 32'(fifo_count), 32'd4);
        chk("s4_no_overrun", 32'(overrun), 32'd0);
        tick();
        req = 1'b0;
        for (int k = 1; k < 5; k++) begin
            do_req(d);
            chk("s4_drain", d, pack4(8'(64 + 4 * k), 8'(65 + 4 * k), 8'(66 + 4 * k), 8'(67 + 4 * k)));
        end

        // Scenario 5: reset mid-word discards the partial bytes
        send_byte(8'hEE); send_byte(8'hFF);
        reset_pulse();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        do_req(d);
        chk("s5_data", d, pack4(8'h11, 8'h22, 8'h33, 8'h44));

        // Reset during the delivery pulse cancels it at once
        send_byte(8'h60); send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
        req = 1'b1;
        wait_ready(n);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_ready_cancel", 32'(input_ready), 32'd0);
        chk("s6_data_clear", input_data, 32'd0);
        req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized traffic: slow requests first (overruns), then fast ones
        for (int c = 0; c < 3000; c++) begin
            bit r;
            @(negedge clk);
            r = input_ready;
            @(posedge clk);
            #1;
            if (req && r) req = 1'b0;
            else if (!req && ($urandom_range(0, (c < 1500) ? 40 : 3) == 0)) req = 1'b1;
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_byte  = 8'($urandom);
            if (r) $display("deliver word %08h (random)", input_data);
        end
        rx_valid = 1'b0;
        req = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
